// File: rtl/lsu_ctrl_if.sv
// Execute-side request, data-memory bus and writeback response of the load/store unit.
// The master side drives requests and plays memory; the slave side is the LSU.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] load_data_out;
  logic        misalign_err;
  logic        bus_err;

  modport master (
    output req_valid, addr_in, store_data_in, mem_rd, mem_wr, funct3, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           resp_valid, load_data_out, misalign_err, bus_err
  );

  modport slave (
    input  req_valid, addr_in, store_data_in, mem_rd, mem_wr, funct3, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           resp_valid, load_data_out, misalign_err, bus_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32 load/store unit: single-outstanding memory transaction with lane steering,
// load extension, alignment checking and a bus timeout.
module lsu_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      clk,
  input  logic      rst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg;
  logic [3:0]              mem_be_reg;
  logic                    mem_we_reg;
  logic [1:0]              addr_lo_reg;
  logic [2:0]              funct3_reg;
  logic                    is_load_reg;
  logic [DATA_WIDTH-1:0]   load_data_reg;
  logic                    misalign_reg;
  logic                    bus_err_reg;
  logic [7:0]              cnt_reg;

  logic [1:0]              size;
  logic                    legal_f3;
  logic                    illegal_req;
  logic                    accept;
  logic                    timeout_hit;
  logic [3:0]              be_req;
  logic [DATA_WIDTH-1:0]   wdata_req;
  logic [DATA_WIDTH-1:0]   rdata_shift;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign size        = bus.funct3[1:0];
  // Stores have no unsigned variants; loads reject size 11 and unsigned word.
  assign legal_f3    = bus.mem_wr ? (!bus.funct3[2] && size != 2'b11)
                                  : (size != 2'b11 && !(bus.funct3[2] && bus.funct3[1]));
  assign illegal_req = (bus.mem_rd && bus.mem_wr) || !legal_f3
                    || (size == 2'b01 && bus.addr_in[0])
                    || (size == 2'b10 && bus.addr_in[1:0] != 2'b00);
  assign accept      = (state_reg == IDLE) && bus.req_valid && (bus.mem_rd || bus.mem_wr);
  assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign be_req[gi] = (size == 2'b10)
                       || (size == 2'b01 && (bus.addr_in[1] == (gi >= 2)))
                       || (size == 2'b00 && bus.addr_in[1:0] == 2'(gi));
      assign wdata_req[8*gi +: 8] = (size == 2'b00) ? bus.store_data_in[7:0] :
                                    (size == 2'b01) ? bus.store_data_in[8*(gi%2) +: 8] :
                                                      bus.store_data_in[8*gi +: 8];
    end
  endgenerate

  assign rdata_shift = bus.mem_rdata >> {addr_lo_reg, 3'b000};

  always_comb begin
    load_ext = bus.mem_rdata;
    case (funct3_reg)
      3'b000:  load_ext = {{24{rdata_shift[7]}},  rdata_shift[7:0]};
      3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_ext = {24'd0, rdata_shift[7:0]};
      3'b101:  load_ext = {16'd0, rdata_shift[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = illegal_req ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ack || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      mem_we_reg    <= 1'b0;
      addr_lo_reg   <= '0;
      funct3_reg    <= '0;
      is_load_reg   <= 1'b0;
      load_data_reg <= '0;
      misalign_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            load_data_reg <= '0;
            misalign_reg  <= illegal_req;
            bus_err_reg   <= 1'b0;
            cnt_reg       <= '0;
            if (!illegal_req) begin
              mem_addr_reg  <= {bus.addr_in[31:2], 2'b00};
              mem_wdata_reg <= wdata_req;
              mem_be_reg    <= be_req;
              mem_we_reg    <= bus.mem_wr;
              addr_lo_reg   <= bus.addr_in[1:0];
              funct3_reg    <= bus.funct3;
              is_load_reg   <= bus.mem_rd;
            end
          end
        end
        ACCESS: begin
          // An ack arriving on the timeout edge still completes normally.
          if (bus.mem_ack) begin
            load_data_reg <= is_load_reg ? load_ext : '0;
          end else if (timeout_hit) begin
            bus_err_reg   <= 1'b1;
            load_data_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RESP: begin
          misalign_reg <= 1'b0;
          bus_err_reg  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = (state_reg == IDLE);
  assign bus.mem_req       = (state_reg == ACCESS);
  assign bus.resp_valid    = (state_reg == RESP);
  assign bus.mem_we        = mem_we_reg;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.mem_be        = mem_be_reg;
  assign bus.mem_wdata     = mem_wdata_reg;
  assign bus.load_data_out = load_data_reg;
  assign bus.misalign_err  = misalign_reg;
  assign bus.bus_err       = bus_err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: transaction-level reference model compared every
// cycle, plus directed transactions with hand-computed expected values.
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int dut_acc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          chk_en = 0;
  bit          m_ready, m_req, m_resp, m_mis, m_bus, m_we, m_load;
  logic [31:0] m_addr, m_wdata, m_ld;
  logic [3:0]  m_be;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  int          m_wait;

  function automatic bit is_illegal(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    bit ok;
    if (rd && wr) return 1;
    if (wr) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!ok) return 1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] f3, int off);
    case (f3 % 4)
      0:       return 4'(1 << off);
      1:       return (off >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'd0:    return (d % 256) * 32'h01010101;
      3'd1:    return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, int off, logic [31:0] word);
    int unsigned v, b, h;
    v = word >> (8 * off);
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(int'(b) - 256)   : b;
      3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1; m_req = 0; m_resp = 0; m_mis = 0; m_bus = 0; m_ld = 0;
      m_addr = 0; m_be = 0; m_we = 0; m_wdata = 0; m_wait = 0;
      chk_en = 1;
    end else if (m_resp) begin
      m_resp = 0; m_ready = 1; m_mis = 0; m_bus = 0;
    end else if (m_req) begin
      if (bus.mem_ack) begin
        m_req = 0; m_resp = 1;
        m_ld = m_load ? model_load(m_f3, int'(m_off), bus.mem_rdata) : 32'd0;
      end else if (m_wait + 1 >= TO) begin
        m_req = 0; m_resp = 1; m_bus = 1; m_ld = 0;
      end else begin
        m_wait++;
      end
    end else if (bus.req_valid && (bus.mem_rd || bus.mem_wr)) begin
      m_ready = 0; m_ld = 0; m_wait = 0;
      if (is_illegal(bus.mem_rd, bus.mem_wr, bus.funct3, bus.addr_in)) begin
        m_resp = 1; m_mis = 1;
      end else begin
        m_req   = 1;
        m_addr  = bus.addr_in - (bus.addr_in % 4);
        m_be    = model_be(bus.funct3, int'(bus.addr_in % 4));
        m_we    = bus.mem_wr;
        m_wdata = model_wdata(bus.funct3, bus.store_data_in);
        m_load  = bus.mem_rd;
        m_f3    = bus.funct3;
        m_off   = bus.addr_in[1:0];
      end
    end
  end

  always @(posedge clk)
    if (!rst && bus.req_valid && bus.req_ready && (bus.mem_rd || bus.mem_wr)) dut_acc++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", bus.req_ready, m_ready);
      chk("m_mem_req", bus.mem_req, m_req);
      chk("m_resp_valid", bus.resp_valid, m_resp);
      chk("m_misalign", bus.misalign_err, m_mis);
      chk("m_bus_err", bus.bus_err, m_bus);
      if (m_req) begin
        chk("m_mem_addr", bus.mem_addr, m_addr);
        chk("m_mem_be", bus.mem_be, m_be);
        chk("m_mem_we", bus.mem_we, m_we);
        chk("m_mem_wdata", bus.mem_wdata, m_wdata);
      end
      if (m_resp) chk("m_load_data", bus.load_data_out, m_ld);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_xfer(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] sd, input logic [31:0] rdat,
                         input int waits, input logic [3:0] xbe, input logic [31:0] xwd,
                         input logic [31:0] xld, input bit xmis);
    bus.req_valid = 1; bus.mem_rd = rd; bus.mem_wr = wr;
    bus.addr_in = a; bus.funct3 = f3; bus.store_data_in = sd;
    @(negedge clk);
    bus.req_valid = 0; bus.mem_rd = 0; bus.mem_wr = 0;
    if (xmis) begin
      chk({nm, "_noreq"}, bus.mem_req, 0);
      chk({nm, "_rv"}, bus.resp_valid, 1);
      chk({nm, "_mis"}, bus.misalign_err, 1);
    end else begin
      chk({nm, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
      chk({nm, "_be"}, bus.mem_be, xbe);
      chk({nm, "_we"}, bus.mem_we, wr);
      if (wr) chk({nm, "_wdata"}, bus.mem_wdata, xwd);
      repeat (waits) @(negedge clk);
      bus.mem_ack = 1; bus.mem_rdata = rdat;
      @(negedge clk);
      bus.mem_ack = 0; bus.mem_rdata = 0;
      chk({nm, "_rv"}, bus.resp_valid, 1);
      chk({nm, "_ld"}, bus.load_data_out, xld);
      chk({nm, "_err"}, {bus.misalign_err, bus.bus_err}, 0);
    end
    @(negedge clk);
    chk({nm, "_ready"}, bus.req_ready, 1);
    $display("txn %s addr=%08h f3=%0d rd=%0d wr=%0d ld=%08h", nm, a, f3, rd, wr, bus.load_data_out);
  endtask

  initial begin
    int n;
    int acc0;
    bit seen;
    bus.req_valid = 0; bus.mem_rd = 0; bus.mem_wr = 0; bus.addr_in = 0;
    bus.funct3 = 0; bus.store_data_in = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    rst = 1;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_outs", {bus.mem_req, bus.mem_we, bus.mem_be, bus.resp_valid,
                     bus.misalign_err, bus.bus_err}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_ld", bus.load_data_out, 0);
    rst = 0;
    @(negedge clk);

    do_xfer("LW",  1, 0, 32'h1000, 3'd2, 0, 32'hDEADBEEF, 0, 4'hF, 0, 32'hDEADBEEF, 0);
    do_xfer("LB",  1, 0, 32'h1003, 3'd0, 0, 32'h80FF1122, 0, 4'h8, 0, 32'hFFFFFF80, 0);
    do_xfer("LBU", 1, 0, 32'h1003, 3'd4, 0, 32'h80FF1122, 0, 4'h8, 0, 32'h00000080, 0);
    do_xfer("LH",  1, 0, 32'h1002, 3'd1, 0, 32'h80FF1122, 1, 4'hC, 0, 32'hFFFF80FF, 0);
    do_xfer("LHU", 1, 0, 32'h1002, 3'd5, 0, 32'h80FF1122, 0, 4'hC, 0, 32'h000080FF, 0);
    do_xfer("LB1", 1, 0, 32'h1001, 3'd0, 0, 32'h80FF1122, 2, 4'h2, 0, 32'h00000011, 0);
    // Ack on the 4th request cycle coincides with the timeout edge and must win.
    do_xfer("SH",  0, 1, 32'h2002, 3'd1, 32'h12345678, 0, 3, 4'hC, 32'h56785678, 0, 0);
    do_xfer("SB",  0, 1, 32'h2001, 3'd0, 32'h000000AB, 32'hFFFFFFFF, 0, 4'h2, 32'hABABABAB, 0, 0);
    do_xfer("SW",  0, 1, 32'h2004, 3'd2, 32'hCAFEF00D, 0, 1, 4'hF, 32'hCAFEF00D, 0, 0);
    do_xfer("LWmis",  1, 0, 32'h1001, 3'd2, 0, 0, 0, 0, 0, 0, 1);
    do_xfer("SHmis",  0, 1, 32'h0003, 3'd1, 0, 0, 0, 0, 0, 0, 1);
    do_xfer("RDWR",   1, 1, 32'h0000, 3'd2, 0, 0, 0, 0, 0, 0, 1);
    do_xfer("SBUill", 0, 1, 32'h0000, 3'd4, 0, 0, 0, 0, 0, 0, 1);
    do_xfer("LF3ill", 1, 0, 32'h0000, 3'd3, 0, 0, 0, 0, 0, 0, 1);

    // Timeout: no ack ever.
    bus.req_valid = 1; bus.mem_rd = 1; bus.addr_in = 32'h3000; bus.funct3 = 3'd2;
    @(negedge clk);
    bus.req_valid = 0; bus.mem_rd = 0;
    n = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.resp_valid) seen = 1;
      else begin
        if (bus.mem_req) n++;
        @(negedge clk);
      end
    end
    chk("to_resp_seen", seen, 1);
    chk("to_req_cycles", n, TO);
    chk("to_bus_err", bus.bus_err, 1);
    chk("to_ld", bus.load_data_out, 0);
    $display("txn TIMEOUT addr=00003000 req_cycles=%0d bus_err=%0d", n, bus.bus_err);
    @(negedge clk);
    do_xfer("LWafterTO", 1, 0, 32'h3004, 3'd2, 0, 32'h01234567, 0, 4'hF, 0, 32'h01234567, 0);

    // Reset mid-transaction, then a stray ack.
    bus.req_valid = 1; bus.mem_rd = 1; bus.addr_in = 32'h4000; bus.funct3 = 3'd2;
    @(negedge clk);
    bus.req_valid = 0; bus.mem_rd = 0;
    chk("rstmid_req_before", bus.mem_req, 1);
    rst = 1;
    @(negedge clk);
    rst = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h55555555;
    chk("rstmid_req_drop", bus.mem_req, 0);
    chk("rstmid_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.mem_ack = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp_valid) seen = 1;
      @(negedge clk);
    end
    chk("rstmid_no_resp", seen, 0);
    $display("txn RESET_ABORT addr=00004000 resp_seen=%0d", seen);

    // Continuous REQ_VALID with always-ack memory: one accept per 3 cycles.
    acc0 = dut_acc;
    bus.req_valid = 1; bus.mem_rd = 1; bus.addr_in = 32'h0040; bus.funct3 = 3'd2;
    bus.mem_ack = 1; bus.mem_rdata = 32'h11223344;
    repeat (9) @(negedge clk);
    bus.req_valid = 0; bus.mem_rd = 0; bus.mem_ack = 0;
    chk("stream_accepts", dut_acc - acc0, 3);
    $display("txn STREAM accepts=%0d", dut_acc - acc0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit for the RV32 execute→memory boundary.
- Consumes the ALU result as the effective address and RS2 as store data.
- Runs a single-outstanding request/acknowledge transaction with data memory.
- Returns aligned, sign/zero-extended load data to writeback, with alignment and bus-timeout error reporting.

Parameters:
DATA_WIDTH, 32, data/address width (only 32 supported)
TIMEOUT_CYCLES, 255, max cycles MEM_REQ is held without MEM_ACK before bus error (1..255)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-high
REQ_VALID  input  1  request from execute stage
REQ_READY  output  1  unit idle, can accept request
ADDR_IN  input  32  effective address (ALU output)
STORE_DATA_IN  input  32  store data (RS2)
MEM_RD  input  1  load request
MEM_WR  input  1  store request
FUNCT3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
MEM_REQ  output  1  memory request, held until ack
MEM_WE  output  1  1=write
MEM_ADDR  output  32  word-aligned address {ADDR[31:2],2'b00}
MEM_BE  output  4  byte enables
MEM_WDATA  output  32  lane-replicated store data
MEM_ACK  input  1  memory completion
MEM_RDATA  input  32  read word, valid when MEM_ACK
RESP_VALID  output  1  one-cycle completion pulse
LOAD_DATA_OUT  output  32  extended load result
MISALIGN_ERR  output  1  qualified by RESP_VALID
BUS_ERR  output  1  qualified by RESP_VALID

Behaviour:
- Reset (sync, active-high):
  - FSM goes to IDLE.
  - MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA, RESP_VALID, LOAD_DATA_OUT, MISALIGN_ERR and BUS_ERR all go to 0.
  - Timeout counter goes to 0.
  - REQ_READY = 1 from the first cycle after reset.
- Reset mid-transaction: MEM_REQ drops at that edge; no response is ever produced for the aborted request.
- FSM states: IDLE, ACCESS, RESP. REQ_READY = (state==IDLE), driven combinationally from state.
- Transfer: REQ_VALID & REQ_READY & (MEM_RD|MEM_WR). ADDR/FUNCT3/data/op are latched at that edge.
  - REQ_VALID with neither MEM_RD nor MEM_WR is not a transfer and is ignored.
- Illegal request, →RESP with MISALIGN_ERR=1 and no memory access. A request is illegal if any of:
  - MEM_RD & MEM_WR both set;
  - FUNCT3 not in the legal set (stores accept only 000/001/010);
  - H/HU with ADDR[0]=1;
  - W with ADDR[1:0]≠0.
- Legal request: IDLE→ACCESS.
  - MEM_REQ=1 from the next cycle; MEM_* outputs held stable while in ACCESS.
- Byte enables:
  - B/BU: 4'b0001<<ADDR[1:0].
  - H/HU: ADDR[1]?1100:0011.
  - W: 1111.
- Store data: SB → {4{D[7:0]}}; SH → {2{D[15:0]}}; SW → D. MEM_WE=1 for stores, 0 for loads.
- ACCESS + MEM_ACK=1 at an edge:
  - Load result = (MEM_RDATA >> 8*ADDR[1:0]), sign-extended for B/H, zero-extended for BU/HU, unmodified for W; registered into LOAD_DATA_OUT. Stores leave LOAD_DATA_OUT = 0.
  - MEM_REQ=0 next cycle; →RESP.
- An ack in the first MEM_REQ cycle is legal. MEM_ACK outside ACCESS is ignored.
- Timeout:
  - Counter increments every ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack, drop MEM_REQ, →RESP with BUS_ERR=1 and LOAD_DATA_OUT=0.
  - An ack on the same edge as the timeout wins (normal completion).
- RESP: RESP_VALID=1 for exactly one cycle; error flags valid in that cycle, 0 otherwise. →IDLE.
- Latency:
  - Zero-wait-state access: accept edge, MEM_REQ cycle (ack), RESP cycle, REQ_READY again the next cycle.
  - Misaligned: RESP_VALID the cycle after accept.
- Counter resets to 0 on every accept.

Test Plan:
- LW ADDR=0x1000, ack on first MEM_REQ cycle with RDATA=0xDEADBEEF → MEM_ADDR=0x1000, BE=1111, WE=0; RESP_VALID next cycle; LOAD_DATA_OUT=0xDEADBEEF; errors 0.
- LB ADDR=0x1003, RDATA=0x80FF1122 → BE=1000, LOAD_DATA_OUT=0xFFFFFF80. Same with LBU → 0x00000080. LH ADDR=0x1002 → 0xFFFF80FF. LHU → 0x000080FF.
- SH ADDR=0x2002, STORE_DATA_IN=0x12345678, ack after 3 wait cycles → MEM_ADDR=0x2000, BE=1100, WDATA=0x56785678, WE=1, MEM_* stable all 4 request cycles, RESP_VALID one cycle, LOAD_DATA_OUT=0.
- LW ADDR=0x1001 and SH ADDR=0x0003 → no MEM_REQ; RESP_VALID with MISALIGN_ERR=1 one cycle after accept. MEM_RD=MEM_WR=1 → same.
- Load with MEM_ACK never asserted, TIMEOUT_CYCLES=4 → MEM_REQ high exactly 4 cycles, then RESP_VALID with BUS_ERR=1; the next request completes normally.
- Assert RST during ACCESS, then ack next cycle → MEM_REQ=0 after the reset edge, no RESP_VALID, REQ_READY=1; REQ_VALID held high continuously accepts a new request only after RESP, one request per transaction.
